// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: synchronizes NCH asynchronous lines and detects qualified
// rising/falling edges. It keeps one pending event per channel and serves the
// pending events round-robin over a single valid/ready port. Per-channel sticky
// overflow flags record any edge that was lost.
module edge_event_arbiter #(
  parameter  int NCH         = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int CW          = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] sig_in,
  input  logic [NCH-1:0] rise_en,
  input  logic [NCH-1:0] fall_en,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [CW-1:0]  evt_ch,
  output logic           evt_is_rise,
  output logic [NCH-1:0] pending,
  output logic [NCH-1:0] overflow,
  input  logic [NCH-1:0] ovf_clr
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  logic [NCH-1:0] sync_q [SYNC_STAGES];
  logic [NCH-1:0] prv_q;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] type_q, type_d;
  logic [NCH-1:0] ovf_q, ovf_d, ovf_set;
  logic [NCH-1:0] s_sync, rise, fall, edge_hit, clr_vec;

  state_t         state_q, state_d;
  logic           evt_valid_q, evt_valid_d;
  logic [CW-1:0]  evt_ch_q, evt_ch_d;
  logic           evt_is_rise_q, evt_is_rise_d;
  logic [CW-1:0]  ptr_q, ptr_d;
  logic           hs;
  logic           found;
  logic [CW-1:0]  sel;

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign rise   = s_sync & ~prv_q & rise_en;
  assign fall   = ~s_sync & prv_q & fall_en;
  assign hs     = evt_valid_q & evt_ready;

  // Synchronizer chain plus previous-value register used for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prv_q <= '0;
    end else begin
      sync_q[0] <= sig_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prv_q <= s_sync;
    end
  end

  // Per-channel capture: a handshake clearing the slot this cycle frees it for
  // a new edge, otherwise the first stored event wins and the newcomer is lost.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign edge_hit[gi] = rise[gi] | fall[gi];
    assign clr_vec[gi]  = hs & (evt_ch_q == CW'(gi));
    assign pend_d[gi]   = edge_hit[gi] | (pend_q[gi] & ~clr_vec[gi]);
    assign type_d[gi]   = (edge_hit[gi] & (~pend_q[gi] | clr_vec[gi])) ? rise[gi] : type_q[gi];
    assign ovf_set[gi]  = edge_hit[gi] & pend_q[gi] & ~clr_vec[gi];
  end

  // Set has priority over clear so a lost edge is never hidden by software
  assign ovf_d = (ovf_q & ~ovf_clr) | ovf_set;

  // Round-robin search: lowest offset from ptr wins, so scan offsets downward
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (pend_q[(int'(ptr_q) + j) % NCH]) begin
        found = 1'b1;
        sel   = CW'((int'(ptr_q) + j) % NCH);
      end
    end
  end

  // Arbiter FSM next-state and registered offer fields
  always_comb begin
    state_d       = state_q;
    evt_valid_d   = evt_valid_q;
    evt_ch_d      = evt_ch_q;
    evt_is_rise_d = evt_is_rise_q;
    ptr_d         = ptr_q;
    case (state_q)
      IDLE: begin
        evt_valid_d = 1'b0;
        if (found) begin
          state_d       = OFFER;
          evt_valid_d   = 1'b1;
          evt_ch_d      = sel;
          evt_is_rise_d = type_q[sel];
        end
      end
      OFFER: begin
        if (hs) begin
          state_d     = IDLE;
          evt_valid_d = 1'b0;
          ptr_d       = (evt_ch_q == CW'(NCH - 1)) ? '0 : evt_ch_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        evt_valid_d = 1'b0;
      end
    endcase
  end

  // State, pending/overflow and offer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      evt_valid_q   <= 1'b0;
      evt_ch_q      <= '0;
      evt_is_rise_q <= 1'b0;
      ptr_q         <= '0;
      pend_q        <= '0;
      type_q        <= '0;
      ovf_q         <= '0;
    end else begin
      state_q       <= state_d;
      evt_valid_q   <= evt_valid_d;
      evt_ch_q      <= evt_ch_d;
      evt_is_rise_q <= evt_is_rise_d;
      ptr_q         <= ptr_d;
      pend_q        <= pend_d;
      type_q        <= type_d;
      ovf_q         <= ovf_d;
    end
  end

  assign evt_valid   = evt_valid_q;
  assign evt_ch      = evt_ch_q;
  assign evt_is_rise = evt_is_rise_q;
  assign pending     = pend_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed testbench for edge_event_arbiter (NCH=4, SYNC_STAGES=2).
module tb_edge_event_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] sig_in;
  logic [3:0] rise_en;
  logic [3:0] fall_en;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_is_rise;
  logic [3:0] pending;
  logic [3:0] overflow;
  logic [3:0] ovf_clr;

  int tests = 0;
  int fails = 0;

  edge_event_arbiter #(.NCH(4), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_in      (sig_in),
    .rise_en     (rise_en),
    .fall_en     (fall_en),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_ch      (evt_ch),
    .evt_is_rise (evt_is_rise),
    .pending     (pending),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for an offered event; a timeout shows up as a failed check
  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && evt_valid !== 1'b1; i++) tick();
    chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
  endtask

  // Wait for an event, check it, then accept it with a one-cycle handshake
  task automatic take_evt(input string tag, input int ch, input logic is_rise);
    logic r;
    wait_valid(tag);
    chk({tag, "_ch"}, 32'(evt_ch), 32'(ch));
    chk({tag, "_rise"}, 32'(evt_is_rise), 32'(is_rise));
    r = evt_ready;
    evt_ready = 1'b1;
    tick();
    evt_ready = r;
    chk({tag, "_drop"}, 32'(evt_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b0; sig_in = 4'h0; rise_en = 4'hF; fall_en = 4'hF;
    evt_ready = 1'b0; ovf_clr = 4'h0;
    repeat (3) tick();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_pend", 32'(pending), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_ch", 32'(evt_ch), 32'h0);
    chk("rst_rise", 32'(evt_is_rise), 32'h0);
    rst = 1'b1;
    repeat (2) tick();

    // 1: three-cycle pulse on channel 2, exact latency of the rise event
    evt_ready = 1'b1;
    sig_in = 4'b0100;
    tick();
    chk("t1_e1_valid", 32'(evt_valid), 32'd0);
    tick();
    tick();
    chk("t1_e3_pend", 32'(pending), 32'h4);
    chk("t1_e3_valid", 32'(evt_valid), 32'd0);
    sig_in = 4'b0000;
    tick();
    chk("t1_e4_valid", 32'(evt_valid), 32'd1);
    take_evt("t1_rise", 2, 1'b1);
    take_evt("t1_fall", 2, 1'b0);
    chk("t1_ovf", 32'(overflow), 32'h0);
    evt_ready = 1'b0;

    // 2: only channel 0 rising edges are enabled
    rise_en = 4'b0001; fall_en = 4'b0000;
    sig_in = 4'hF;
    take_evt("t2_r0a", 0, 1'b1);
    chk("t2_pend_a", 32'(pending), 32'h0);
    sig_in = 4'h0;
    repeat (5) tick();
    chk("t2_pend_b", 32'(pending), 32'h0);
    chk("t2_valid_b", 32'(evt_valid), 32'd0);
    sig_in = 4'hF;
    take_evt("t2_r0b", 0, 1'b1);
    sig_in = 4'h0;
    repeat (5) tick();
    chk("t2_pend_c", 32'(pending), 32'h0);

    // 3: grant channel 3 so the pointer wraps to 0, then all four at once
    rise_en = 4'hF; fall_en = 4'h0;
    sig_in = 4'b1000;
    take_evt("t3_pre", 3, 1'b1);
    sig_in = 4'h0;
    repeat (5) tick();
    evt_ready = 1'b1;
    sig_in = 4'hF;
    take_evt("t3_g0", 0, 1'b1);
    chk("t3_pend", 32'(pending), 32'hE);
    take_evt("t3_g1", 1, 1'b1);
    take_evt("t3_g2", 2, 1'b1);
    take_evt("t3_g3", 3, 1'b1);
    fall_en = 4'b1010;
    sig_in = 4'b0101;
    take_evt("t3_h1", 1, 1'b0);
    take_evt("t3_h3", 3, 1'b0);
    evt_ready = 1'b0;

    // 4: second edge on an offered channel overflows, first type is kept
    fall_en = 4'hF;
    sig_in = 4'b0111;
    wait_valid("t4");
    chk("t4_ch", 32'(evt_ch), 32'd1);
    chk("t4_rise", 32'(evt_is_rise), 32'd1);
    sig_in = 4'b0101;
    repeat (4) tick();
    chk("t4_pend", 32'(pending), 32'h2);
    chk("t4_ovf", 32'(overflow), 32'h2);
    chk("t4_hold_valid", 32'(evt_valid), 32'd1);
    chk("t4_hold_ch", 32'(evt_ch), 32'd1);
    chk("t4_hold_rise", 32'(evt_is_rise), 32'd1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("t4_pend_acc", 32'(pending), 32'h0);
    chk("t4_valid_acc", 32'(evt_valid), 32'd0);
    chk("t4_ovf_sticky", 32'(overflow), 32'h2);
    ovf_clr = 4'b0010;
    tick();
    ovf_clr = 4'b0000;
    chk("t4_ovf_clr", 32'(overflow), 32'h0);

    // 5: new edge on channel 0 lands in the same cycle as its handshake
    sig_in = 4'b0100;
    wait_valid("t5");
    chk("t5_ch", 32'(evt_ch), 32'd0);
    chk("t5_rise", 32'(evt_is_rise), 32'd0);
    sig_in = 4'b0101;
    tick();
    tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("t5_pend", 32'(pending), 32'h1);
    chk("t5_ovf", 32'(overflow), 32'h0);
    chk("t5_valid", 32'(evt_valid), 32'd0);
    take_evt("t5_re", 0, 1'b1);

    // 5b: ovf_clr coinciding with a new overflow leaves the flag set
    sig_in = 4'b0001;
    wait_valid("t5b");
    chk("t5b_ch", 32'(evt_ch), 32'd2);
    chk("t5b_rise", 32'(evt_is_rise), 32'd0);
    sig_in = 4'b0101;
    tick();
    tick();
    ovf_clr = 4'b0100;
    tick();
    ovf_clr = 4'b0000;
    chk("t5b_ovf", 32'(overflow), 32'h4);
    chk("t5b_valid", 32'(evt_valid), 32'd1);
    chk("t5b_hold_rise", 32'(evt_is_rise), 32'd0);

    // 6: asynchronous reset in the middle of an offer
    rst = 1'b0;
    #1;
    chk("t6_valid", 32'(evt_valid), 32'd0);
    chk("t6_pend", 32'(pending), 32'h0);
    chk("t6_ovf", 32'(overflow), 32'h0);
    tick();
    rise_en = 4'b0100; fall_en = 4'hF;
    rst = 1'b1;
    take_evt("t6_held", 2, 1'b1);
    repeat (10) tick();
    chk("t6_once_valid", 32'(evt_valid), 32'd0);
    chk("t6_once_pend", 32'(pending), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
